// File: rtl/xy_seq_pkg.sv
// rtl/xy_seq_pkg.sv - shared state encoding and symbol constants for the X/Y sequence generator
package xy_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYM  = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_e;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_Y    = 2'b01;
  localparam logic [1:0] SYM_X    = 2'b10;
  localparam logic [1:0] SYM_BOTH = 2'b11;

endpackage

// File: rtl/cycle_down_counter.sv
// rtl/cycle_down_counter.sv - loadable down-counter that stops at zero and flags it
module cycle_down_counter #(
  parameter int W = 3
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         LOAD,
  input  logic [W-1:0] VALUE,
  output logic         ZERO
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = VALUE;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/xy_seq_gen.sv
// rtl/xy_seq_gen.sv - emits a latched code word as timed 2-bit symbols on the X/Y wires
module xy_seq_gen
  import xy_seq_pkg::*;
#(
  parameter int NUM_SYM     = 4,
  parameter int HOLD_CYCLES = 1,
  parameter int GAP_CYCLES  = 5
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [2*NUM_SYM-1:0] CODE,
  output logic                 X,
  output logic                 Y,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_SYM + 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_SYM - 1);

  state_e               state_q, state_d;
  logic [2*NUM_SYM-1:0] shift_q, shift_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [1:0]           xy_q, xy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_load;
  logic [CW-1:0]        cnt_value;
  logic                 cnt_zero;

  cycle_down_counter #(.W(CW)) u_cnt (
    .CLK   (CLK),
    .RST   (RST),
    .LOAD  (cnt_load),
    .VALUE (cnt_value),
    .ZERO  (cnt_zero)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    idx_d     = idx_q;
    xy_d      = xy_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    cnt_load  = 1'b0;
    cnt_value = HOLD_LD;
    case (state_q)
      IDLE: begin
        xy_d   = SYM_NONE;
        busy_d = 1'b0;
        if (START && !ABORT) begin
          // shift_q keeps only the symbols still to be sent
          shift_d  = CODE >> 2;
          xy_d     = CODE[1:0];
          idx_d    = '0;
          busy_d   = 1'b1;
          cnt_load = 1'b1;
          state_d  = SYM;
        end
      end
      SYM: begin
        if (ABORT) begin
          xy_d    = SYM_NONE;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_zero) begin
          if (idx_q == LAST_IDX) begin
            xy_d    = SYM_NONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FIN;
          end else if (GAP_CYCLES > 0) begin
            xy_d      = SYM_NONE;
            cnt_load  = 1'b1;
            cnt_value = GAP_LD;
            state_d   = GAP;
          end else begin
            xy_d     = shift_q[1:0];
            shift_d  = shift_q >> 2;
            idx_d    = idx_q + IW'(1);
            cnt_load = 1'b1;
          end
        end
      end
      GAP: begin
        if (ABORT) begin
          xy_d    = SYM_NONE;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt_zero) begin
          xy_d     = shift_q[1:0];
          shift_d  = shift_q >> 2;
          idx_d    = idx_q + IW'(1);
          cnt_load = 1'b1;
          state_d  = SYM;
        end
      end
      FIN: begin
        xy_d    = SYM_NONE;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      xy_q    <= SYM_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      xy_q    <= xy_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign X    = xy_q[1];
  assign Y    = xy_q[0];
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule
